conv_bias_relu_pool: RTL



---
 rtl/conv_bias_relu_pool.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/conv_bias_relu_pool.sv
// -----------------------------------------------------------------------------
// conv_bias_relu_pool
//   Post-processing for the conv PE accumulator stream. The stream arrives in
//   raster order. Each pixel gets a bias added, then ReLU, then an arithmetic
//   right shift that saturates to DATA_W signed. The result is max-pooled
//   2x2 with stride 2 using a half-row line buffer.
//
//   Stage A: bias + ReLU + requantize, registered with a_valid.
//   Stage B: horizontal pair max, then vertical max against the line buffer.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   valid_in    sum_in valid this cycle
//   sum_in      signed conv accumulator (ACC_W)
//   bias        signed per-feature-map bias (ACC_W), static within a frame
//   pool_out    pooled pixel (DATA_W signed, always >= 0)
//   valid_out   one-cycle strobe qualifying pool_out
//   frame_done  one-cycle pulse with the last pooled pixel of a frame
//
// Build option:
//   CONV_QUANT_ROUND_EN  when defined, adds 2^(SHIFT-1) before the shift
//                        (round-half-up). Latency is unchanged.
// -----------------------------------------------------------------------------
module conv_bias_relu_pool #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24,
    parameter int SHIFT  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic signed [ACC_W-1:0]  sum_in,
    input  logic signed [ACC_W-1:0]  bias,
    output logic signed [DATA_W-1:0] pool_out,
    output logic                     valid_out,
    output logic                     frame_done
);

    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LBN  = IMG_W / 2;
    localparam int LBW  = (LBN > 1) ? $clog2(LBN) : 1;
    // Two guard bits: one for the bias add, one for the rounding add.
    localparam int QW   = ACC_W + 2;
    localparam logic [QW-1:0] PX_MAX = QW'({(DATA_W-1){1'b1}});
`ifdef CONV_QUANT_ROUND_EN
    localparam logic [QW-1:0] RND = (SHIFT > 0) ? (QW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`endif

    // ---------------- Stage A: bias, ReLU, requantize ----------------
    logic signed [ACC_W:0] b_sum;
    logic [QW-1:0]         r_val;
    logic [QW-1:0]         q_val;
    logic [DATA_W-1:0]     px_new;

    logic                  a_valid_d, a_valid_q;
    logic [DATA_W-1:0]     a_px_d, a_px_q;

    always_comb begin
        // Add the sign-extended operands so the sum cannot wrap.
        b_sum = {sum_in[ACC_W-1], sum_in} + {bias[ACC_W-1], bias};
        r_val = b_sum[ACC_W] ? '0 : {1'b0, b_sum};
`ifdef CONV_QUANT_ROUND_EN
        r_val = r_val + RND;
`endif
        // r_val is non-negative here, so a logical shift equals the arithmetic shift.
        q_val  = r_val >> SHIFT;
        px_new = (q_val > PX_MAX) ? PX_MAX[DATA_W-1:0] : q_val[DATA_W-1:0];

        a_valid_d = valid_in;
        a_px_d    = valid_in ? px_new : a_px_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q <= 1'b0;
            a_px_q    <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            a_px_q    <= a_px_d;
        end
    end

    // ---------------- Stage B: 2x2 max pool ----------------
    logic [CW-1:0]     col_d, col_q;
    logic [RW-1:0]     row_d, row_q;
    logic [DATA_W-1:0] h_hold_d, h_hold_q;
    logic [DATA_W-1:0] pool_out_d, pool_out_q;
    logic              valid_out_d, valid_out_q;
    logic              frame_done_d, frame_done_q;

    logic [DATA_W-1:0] linebuf_q [LBN];
    logic [LBW-1:0]    lb_idx;
    logic [DATA_W-1:0] lb_rd;
    logic [DATA_W-1:0] hmax;
    logic              lb_we;

    always_comb begin
        lb_idx = LBW'(col_q >> 1);
        lb_rd  = linebuf_q[lb_idx];
        // All pixels are non-negative, so an unsigned compare is correct.
        hmax   = (a_px_q > h_hold_q) ? a_px_q : h_hold_q;

        col_d        = col_q;
        row_d        = row_q;
        h_hold_d     = h_hold_q;
        pool_out_d   = pool_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;

        if (a_valid_q) begin
            if (!col_q[0]) begin
                h_hold_d = a_px_q;
            end else if (!row_q[0]) begin
                // Top half of the window: park the pair max for the next row.
                lb_we = 1'b1;
            end else begin
                pool_out_d   = (lb_rd > hmax) ? lb_rd : hmax;
                valid_out_d  = 1'b1;
                frame_done_d = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
            end

            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            h_hold_q     <= '0;
            pool_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            h_hold_q     <= h_hold_d;
            pool_out_q   <= pool_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // The line buffer is not reset: every entry is written on an even row
    // before the following odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_we) linebuf_q[lb_idx] <= hmax;
    end

    assign pool_out   = pool_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule
